audio_sample_bank: RTL
======================

Name: audio_sample_bank

Overview:
- Parametrised multi-channel audio sample store for the recorder datapath.
- Successor to the fixed two-memory arrangement: one inferred block RAM per channel, all sharing one address.
- Record mode captures paced samples from the ADC side; playback mode replays them to the DAC side at the playback tick rate, once or looped.
- Sits between the audio codec interface and the top-level control FSM.

Parameters:
SAMPLE_W, 16, bits per sample per channel
CHANNELS, 2, number of audio channels; one RAM each, common address
DEPTH, 4096, samples per channel; ADDR_W = $clog2(DEPTH) is derived locally, and DEPTH must be at least 2

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
rec_start  in  1  one-cycle command: begin recording at address 0
play_start  in  1  one-cycle command: begin playback at address 0
stop  in  1  one-cycle command: end the current operation
loop_en  in  1  sampled on every playback wrap; 1 = restart playback at address 0
in_valid  in  1  a record sample is present
in_data  in  CHANNELS*SAMPLE_W  record sample; channel c occupies bits [c*SAMPLE_W +: SAMPLE_W]
in_ready  out  1  high only in RECORD; a sample transfers when in_valid && in_ready
sample_tick  in  1  playback pacing strobe, one cycle per output sample
out_valid  out  1  one-cycle pulse; out_data is valid while it is high
out_data  out  CHANNELS*SAMPLE_W  playback sample, same channel packing as in_data
state  out  2  0 = IDLE, 1 = RECORD, 2 = PLAY
rec_len  out  ADDR_W+1  number of valid stored samples (0..DEPTH)
full  out  1  sticky; set when a recording reached DEPTH; cleared by the next rec_start

Behaviour:
- Reset values: state = IDLE, rec_len = 0, full = 0, out_valid = 0, out_data = 0, in_ready = 0, write and read address counters = 0. RAM contents are not cleared.
- Command priority within one cycle: stop, then rec_start, then play_start. Start commands are ignored unless state is IDLE. stop in IDLE has no effect.
- IDLE -> RECORD on rec_start:
  - Write address cleared to 0, full cleared, rec_len cleared to 0.
  - in_ready goes high on the following cycle.
- In RECORD, each transfer:
  - Writes in_data into all channel RAMs at the write address.
  - Increments the write address; rec_len = write address + 1 in the same cycle.
- On the transfer to address DEPTH-1:
  - rec_len = DEPTH, full = 1.
  - Next state is IDLE; in_ready is low from the next cycle.
  - There is no wrap and no overwrite.
- stop in RECORD:
  - Next state is IDLE; rec_len holds its current count.
  - A transfer in the same cycle as stop is discarded.
- IDLE -> PLAY on play_start, only if rec_len != 0; read address cleared to 0. Otherwise play_start is ignored.
- In PLAY, each sample_tick issues a RAM read at the read address:
  - Read latency is 1 cycle: out_valid = 1 and out_data = RAM data on the cycle after the tick.
  - Read address increments after each issue.
- Wrap at the end of playback: when the issued address equals rec_len-1, loop_en is sampled that cycle.
  - loop_en = 1: read address goes to 0 and state stays PLAY.
  - loop_en = 0: state goes to IDLE; the final out_valid pulse still occurs on the next cycle.
- stop in PLAY:
  - Next state is IDLE.
  - A read issued in the same cycle is cancelled and produces no out_valid.
  - A read already in flight from the previous cycle still produces its out_valid.
- sample_tick outside PLAY is ignored. out_valid is never high for two consecutive cycles unless sample_tick was high on consecutive cycles.
- out_data holds its last value when out_valid is low.
- Reset mid-operation: immediately returns to the reset values. Prior samples become inaccessible because rec_len = 0.

Test Plan:
- Reset, then idle, with DEPTH=8, CHANNELS=2, SAMPLE_W=16 -> state=0, in_ready=0, rec_len=0, out_valid=0.
- rec_start, then 5 transfers of {16'hA000+i, 16'h5000+i}, then stop -> rec_len=5, full=0, state=0. Then play_start, 5 ticks spaced 3 cycles apart -> 5 out_valid pulses, each 1 cycle after its tick, data in order; state returns to 0.
- Record with in_valid held high for 10 cycles -> exactly 8 writes, rec_len=8, full=1, in_ready low after the 8th transfer, state=0.
- rec_len=3, loop_en=1, 7 ticks -> output sequence is addresses 0,1,2,0,1,2,0. Then loop_en=0 -> ends after address 2 and state returns to 0.
- play_start with rec_len=0 -> state stays 0. rec_start and play_start in the same cycle -> RECORD. stop and a tick in the same cycle -> no out_valid.
- reset asserted mid-PLAY after 2 ticks -> the next cycle shows state=0, rec_len=0, out_valid=0; play_start is then ignored.

Source files
------------

// File: rtl/audio_sample_bank_if.sv
// Sample stream bundle for audio_sample_bank: ADC-side record handshake and
// DAC-side paced playback, channel c packed at [c*SAMPLE_W +: SAMPLE_W].
interface audio_sample_bank_if #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 16
) ();
    logic                         in_valid;
    logic [CHANNELS*SAMPLE_W-1:0] in_data;
    logic                         in_ready;
    logic                         sample_tick;
    logic                         out_valid;
    logic [CHANNELS*SAMPLE_W-1:0] out_data;

    modport master (
        output in_valid, in_data, sample_tick,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, sample_tick,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/audio_sample_bank.sv
// Multi-channel record/playback sample store: one RAM per channel on a common
// address, recorded from the ADC handshake and replayed on sample_tick.
module audio_sample_bank_ram #(
    parameter int W      = 16,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [W-1:0]      wdata,
    output logic [W-1:0]      rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[addr] <= wdata;
    end

    // rdata only moves on a read, so it doubles as the held playback output
    always_ff @(posedge clock) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[addr];
    end
endmodule

module audio_sample_bank #(
    parameter int SAMPLE_W = 16,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4096,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic              loop_en,
    audio_sample_bank_if.slave bus,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   rec_len,
    output logic              full
);
    localparam int STAGES = 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REC = 2'd1, S_PLAY = 2'd2} st_t;

    st_t                               st;
    logic [ADDR_W-1:0]                 wr_addr, rd_addr, ram_addr;
    logic                              in_ready_q;
    logic                              wr_en, rd_issue;
    logic [ADDR_W:0]                   rd_last;
    logic [STAGES:0]                   vld_pipe;
    logic [CHANNELS-1:0][SAMPLE_W-1:0] wr_lane, rd_lane;

    assign wr_en    = (st == S_REC) && bus.in_valid && in_ready_q && !stop;
    assign rd_issue = (st == S_PLAY) && bus.sample_tick && !stop;
    assign ram_addr = (st == S_PLAY) ? rd_addr : wr_addr;
    assign rd_last  = rec_len - {{ADDR_W{1'b0}}, 1'b1};
    assign wr_lane  = bus.in_data;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.out_data  = rd_lane;
    assign state         = st;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        audio_sample_bank_ram #(
            .W(SAMPLE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
        ) u_ram (
            .clock (clock),
            .reset (reset),
            .we    (wr_en),
            .re    (rd_issue),
            .addr  (ram_addr),
            .wdata (wr_lane[c]),
            .rdata (rd_lane[c])
        );
    end

    assign vld_pipe[0] = rd_issue;

    always_ff @(posedge clock) begin
        if (reset) vld_pipe[STAGES:1] <= '0;
        else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st         <= S_IDLE;
            wr_addr    <= '0;
            rd_addr    <= '0;
            rec_len    <= '0;
            full       <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            case (st)
                S_IDLE: begin
                    // stop outranks both starts even though it has nothing to end
                    if (stop) begin
                        st <= S_IDLE;
                    end else if (rec_start) begin
                        st         <= S_REC;
                        wr_addr    <= '0;
                        rec_len    <= '0;
                        full       <= 1'b0;
                        in_ready_q <= 1'b1;
                    end else if (play_start && rec_len != '0) begin
                        st      <= S_PLAY;
                        rd_addr <= '0;
                    end
                end
                S_REC: begin
                    if (stop) begin
                        st         <= S_IDLE;
                        in_ready_q <= 1'b0;
                    end else if (wr_en) begin
                        wr_addr <= wr_addr + 1'b1;
                        rec_len <= {1'b0, wr_addr} + 1'b1;
                        // last slot: no wrap, the recording simply ends
                        if (wr_addr == LAST_ADDR) begin
                            full       <= 1'b1;
                            st         <= S_IDLE;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                S_PLAY: begin
                    if (stop) begin
                        st <= S_IDLE;
                    end else if (rd_issue) begin
                        if ({1'b0, rd_addr} == rd_last) begin
                            if (loop_en) rd_addr <= '0;
                            else         st      <= S_IDLE;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    st         <= S_IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
